// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: shares one single-precision FP_Mul among NUM_REQ requesters.
// Round-robin grant, one operation in flight, valid/ready response return.
// Works with a multiplier of any latency (Valid_In held until Valid_Out).
// Optional statistics counters are enabled by defining FP_MUL_ARB_STATS_EN.
module fp_mul_arbiter #(
  parameter int BUS_WIDTH = 32,
  parameter int NUM_REQ   = 4,
  parameter int REQ_IDX_W = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_b,
  output logic [BUS_WIDTH-1:0]         mul_a,
  output logic [BUS_WIDTH-1:0]         mul_b,
  output logic                         mul_valid,
  input  logic [BUS_WIDTH-1:0]         mul_result,
  input  logic                         mul_valid_out,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [BUS_WIDTH-1:0]         rsp_data,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic                         busy
`ifdef FP_MUL_ARB_STATS_EN
  ,
  output logic [15:0]                  op_count,
  output logic [15:0]                  stall_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arbState;

  arbState                state;
  arbState                nextState;
  logic [REQ_IDX_W-1:0]   ptr;        // first requester to consider next time
  logic [REQ_IDX_W-1:0]   grantIdx;   // owner of the operation in flight
  logic [REQ_IDX_W-1:0]   grantSel;   // winner of the current search
  logic [REQ_IDX_W-1:0]   candIdx;
  logic                   anyReq;
  int                     cand;
  logic                   doGrant;
  logic                   doCapture;
  logic                   doDone;

  // Round-robin search: first valid requester at or after ptr, wrapping.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    anyReq   = 1'b0;
    grantSel = '0;
    candIdx  = '0;
    cand     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      candIdx = REQ_IDX_W'(cand);
      if (!anyReq && req_valid[candIdx]) begin
        anyReq   = 1'b1;
        grantSel = candIdx;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register updates from the
    // values present before the edge, independent of statement order.
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state and handshake outputs.
  always_comb begin
    nextState = state;
    req_ready = '0;
    rsp_valid = '0;
    mul_valid = 1'b0;
    doGrant   = 1'b0;
    doCapture = 1'b0;
    doDone    = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        // The grant is combinational from req_valid, so it is masked while
        // rst is held to keep every output at zero during reset.
        if (anyReq && !rst) begin
          req_ready[grantSel] = 1'b1;
          doGrant             = 1'b1;
          nextState           = ISSUE;
        end
      end
      ISSUE: begin
        mul_valid = 1'b1;
        if (mul_valid_out) begin
          doCapture = 1'b1;
          nextState = RESP;
        end
      end
      RESP: begin
        rsp_valid[grantIdx] = 1'b1;
        if (rsp_ready[grantIdx]) begin
          doDone    = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Operand latch, pointer update and product capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      grantIdx <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      rsp_data <= '0;
    end else begin
      if (doGrant) begin
        grantIdx <= grantSel;
        mul_a    <= req_a[grantSel*BUS_WIDTH +: BUS_WIDTH];
        mul_b    <= req_b[grantSel*BUS_WIDTH +: BUS_WIDTH];
        ptr      <= (grantSel == REQ_IDX_W'(NUM_REQ - 1)) ? '0
                                                          : grantSel + REQ_IDX_W'(1);
      end
      if (doCapture) rsp_data <= mul_result;
    end
  end

`ifdef FP_MUL_ARB_STATS_EN
  // Saturating counters: completed handshakes and back-pressured RESP cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count    <= '0;
      stall_count <= '0;
    end else begin
      if (doDone && op_count != 16'hFFFF) op_count <= op_count + 16'd1;
      if (state == RESP && !rsp_ready[grantIdx] && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule
